// File: rtl/sys_array_pkg.sv
// ============================================================================
// Module      : sys_array_pkg
// Description : Shared types, default sizes and width helpers for the
//               systolic-array input feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_array_pkg;

  // Default geometry of the feeder
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ARRAY_L    = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  // FIFO pointer width; a depth of 1 still needs a 1-bit pointer
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Flush counter width: must hold 0..ARRAY_L-1
  function automatic int fcnt_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

  localparam int PTR_W  = ptr_w(DEF_FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FCNT_W = fcnt_w(DEF_ARRAY_L);

  // One input vector: element j feeds array column j
  typedef logic [0:DEF_ARRAY_L-1][DEF_DATA_WIDTH-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/sys_array_feeder_if.sv
// ============================================================================
// Module      : sys_array_feeder_if
// Description : Input handshake, batch control and skewed array bus of the
//               feeder. master = producer/controller side, slave = feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sys_array_feeder_if
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_L    = DEF_ARRAY_L
);
  logic                                  start;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]    in_data;
  logic                                  in_last;
  logic [0:ARRAY_L-1][DATA_WIDTH-1:0]    input_module;
  logic [0:ARRAY_L-1]                    lane_valid;
  logic                                  busy;
  logic                                  done;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, input_module, lane_valid, busy, done
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, input_module, lane_valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/sys_array_skew_lane.sv
// ============================================================================
// Module      : sys_array_skew_lane
// Description : DEPTH-deep register chain carrying one lane's data + valid.
//               Data is forced to zero whenever valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_array_skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic [DATA_WIDTH-1:0] i_data,
  input  wire logic                  i_valid,
  output logic      [DATA_WIDTH-1:0] o_data,
  output logic                       o_valid
);

  logic [DATA_WIDTH-1:0] r_data  [DEPTH];
  logic                  r_valid [DEPTH];

  // Shift the lane every cycle; invalid slots always carry zero data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= '0;
        r_valid[i] <= 1'b0;
      end
    end else begin
      r_data[0]  <= i_valid ? i_data : '0;
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i]  <= r_data[i-1];
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sys_array_feeder.sv
// ============================================================================
// Module      : sys_array_feeder
// Description : Buffers input vectors in a small FIFO, releases a batch on
//               start (until in_last), and skews lane j by j cycles before
//               driving the systolic array columns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_L    = DEF_ARRAY_L,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  sys_array_feeder_if.slave  bus
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = fcnt_w(ARRAY_L);

  typedef logic [0:ARRAY_L-1][DATA_WIDTH-1:0] lvec_t;

  lvec_t               r_mem_data [FIFO_DEPTH];
  logic                r_mem_last [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  feeder_state_t       r_state;
  logic [FW-1:0]       r_fcnt;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  lvec_t               w_pop_data;
  logic                w_pop_last;
  logic                w_flush_end;
  lvec_t               w_lane_data;
  logic [0:ARRAY_L-1]  w_lane_valid;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.in_valid && !w_full;
  assign w_pop       = (r_state == STREAM) && !w_empty;
  assign w_pop_data  = w_pop ? r_mem_data[r_rd_ptr] : '0;
  assign w_pop_last  = w_pop && r_mem_last[r_rd_ptr];
  assign w_flush_end = (r_state == FLUSH) && (r_fcnt == FW'(ARRAY_L - 1));

  // FIFO storage; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.in_data;
      r_mem_last[r_wr_ptr] <= bus.in_last;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth wraps naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Batch control: IDLE -> STREAM on start, STREAM -> FLUSH on last pop,
  // FLUSH waits for the last lane to drain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) r_state <= STREAM;
        end
        STREAM: begin
          if (w_pop_last) begin
            r_state <= FLUSH;
            r_fcnt  <= '0;
          end
        end
        FLUSH: begin
          if (w_flush_end) r_state <= IDLE;
          else             r_fcnt  <= r_fcnt + FW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lane j gets a (j+1)-deep chain so it trails lane 0 by j cycles
  generate
    for (genvar j = 0; j < ARRAY_L; j++) begin : g_lane
      sys_array_skew_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (j + 1)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (w_pop_data[j]),
        .i_valid (w_pop),
        .o_data  (w_lane_data[j]),
        .o_valid (w_lane_valid[j])
      );
    end
  endgenerate

  assign bus.input_module = w_lane_data;
  assign bus.lane_valid   = w_lane_valid;
  assign bus.in_ready     = !w_full;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = w_flush_end;

endmodule

`default_nettype wire
